ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter.
//
// Sends one byte to a PS/2 device. The sequence is: inhibit the clock line,
// request-to-send (data pulled low, clock released), shift 8 data bits LSB
// first plus odd parity and stop on the device-generated clock, then check
// the device acknowledge and wait for both lines to be released.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the clock line is held low before RTS
//   TIMEOUT_CYCLES  max clk cycles between device clock falls, and for the
//                   final line release
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    one-cycle send request, honoured only while rdy=1
//   data     byte to send, captured on the accepted start cycle
//   rdy      idle, ready to accept start
//   done     one-cycle pulse: frame sent and acknowledged
//   err      one-cycle pulse: timeout or missing acknowledge
//   ps2c_i   PS/2 clock line level (asynchronous)
//   ps2d_i   PS/2 data line level (asynchronous)
//   ps2c_oe  1 = pull PS/2 clock low, 0 = release
//   ps2d_oe  1 = pull PS/2 data low, 0 = release
//
// Build option:
//   PS2_HOST_TX_FILTER_EN  when defined, the device clock is glitch filtered:
//                          it only changes after 8 consecutive equal
//                          synchronised samples (7 cycles extra latency).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       done,
  output logic       err,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_RTS     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Line synchronisers; bit 0 = clock line, bit 1 = data line.
  logic [1:0] line_raw;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic       c_sync;
  logic       d_sync;
  logic       c_cond;
  logic       c_prev_reg;
  logic       fall;

  assign line_raw = {ps2d_i, ps2c_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
    end else begin
      sync1_reg <= line_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign c_sync = sync2_reg[0];
  assign d_sync = sync2_reg[1];

`ifdef PS2_HOST_TX_FILTER_EN
  // The window holds the current synchronised sample plus the previous 7;
  // the conditioned clock follows only when all 8 agree, otherwise it holds.
  logic [6:0] filt_hist_reg;
  logic       filt_cond_reg;
  logic [7:0] filt_win;

  assign filt_win = {filt_hist_reg, c_sync};

  always_comb begin
    c_cond = filt_cond_reg;
    if (&filt_win) begin
      c_cond = 1'b1;
    end else if (~|filt_win) begin
      c_cond = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_hist_reg <= 7'h7F;
      filt_cond_reg <= 1'b1;
    end else begin
      filt_hist_reg <= filt_win[6:0];
      filt_cond_reg <= c_cond;
    end
  end
`else
  assign c_cond = c_sync;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_prev_reg <= 1'b1;
    end else begin
      c_prev_reg <= c_cond;
    end
  end

  assign fall = c_prev_reg & ~c_cond;

  // Frame control
  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       idx_reg;
  logic [3:0]       idx_nx;
  logic [9:0]       frame_reg;   // {stop, parity, data[7:0]}, bit order of the wire
  logic             ps2c_oe_reg;
  logic             ps2d_oe_reg;
  logic             done_reg;
  logic             err_reg;

  assign idx_nx = idx_reg + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      frame_reg   <= '0;
      ps2c_oe_reg <= 1'b0;
      ps2d_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ps2c_oe_reg <= 1'b0;
          ps2d_oe_reg <= 1'b0;
          if (start) begin
            frame_reg   <= {1'b1, ~^data, data};
            state_reg   <= ST_INHIBIT;
            ps2c_oe_reg <= 1'b1;
            cnt_reg     <= '0;
            idx_reg     <= '0;
          end
        end

        ST_INHIBIT: begin
          // Device clock activity here is device-to-host traffic being
          // inhibited, so falls are deliberately not looked at.
          if (cnt_reg == INH_LAST) begin
            state_reg   <= ST_RTS;
            ps2c_oe_reg <= 1'b0;
            ps2d_oe_reg <= 1'b1;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          // RTS, SHIFT, ACK, RELEASE share the inter-fall watchdog. A fall on
          // the terminal count wins over the timeout.
          if (!fall && cnt_reg == TMO_LAST) begin
            state_reg   <= ST_IDLE;
            ps2c_oe_reg <= 1'b0;
            ps2d_oe_reg <= 1'b0;
            err_reg     <= 1'b1;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= fall ? '0 : cnt_reg + CNT_W'(1);
            case (state_reg)
              ST_RTS: begin
                if (fall) begin
                  state_reg   <= ST_SHIFT;
                  idx_reg     <= '0;
                  ps2d_oe_reg <= ~frame_reg[0];
                end
              end
              ST_SHIFT: begin
                // idx_reg is the wire bit currently driven; each fall moves to
                // the next one. Bit 9 is the stop bit, which releases the line.
                if (fall) begin
                  idx_reg     <= idx_nx;
                  ps2d_oe_reg <= ~frame_reg[idx_nx];
                  if (idx_nx == 4'd9) begin
                    state_reg <= ST_ACK;
                  end
                end
              end
              ST_ACK: begin
                if (fall) begin
                  idx_reg     <= idx_nx;
                  ps2d_oe_reg <= 1'b0;
                  if (!d_sync) begin
                    state_reg <= ST_RELEASE;
                  end else begin
                    state_reg <= ST_IDLE;
                    err_reg   <= 1'b1;
                  end
                end
              end
              ST_RELEASE: begin
                if (c_sync && d_sync) begin
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
                end
              end
              default: begin
                state_reg   <= ST_IDLE;
                ps2c_oe_reg <= 1'b0;
                ps2d_oe_reg <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // rdy is gated by rst so it reads 0 for the whole reset assertion.
  assign rdy     = (state_reg == ST_IDLE) & ~rst;
  assign done    = done_reg;
  assign err     = err_reg;
  assign ps2c_oe = ps2c_oe_reg;
  assign ps2d_oe = ps2d_oe_reg;

endmodule
